// File: rtl/sreg8_serializer.sv
// Parallel-to-serial feeder for an 8-bit serial-in shift register: a one-word
// holding buffer behind a valid/ready port, optional inter-word gap, Pause stall.
module sreg8_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             DataValid,
   output logic             DataReady,
   input  logic             Pause,
   output logic             ShiftOut,
   output logic             ShiftEnable,
   output logic             WordDone,
   output logic             Busy
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_sh, w_sh_nxt, r_hold, w_sh_shifted;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [3:0]       r_gc, w_gc_nxt;
   logic             r_hold_v, w_hold_v_nxt;
   logic             w_accept, w_load, w_last;

   assign DataReady    = ~r_hold_v & ~Reset;
   assign w_accept     = DataValid & DataReady;
   assign Busy         = (r_state != ST_IDLE) | r_hold_v;
   assign w_last       = (r_cnt == CW'(WIDTH - 1));
   assign w_sh_shifted = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_cnt_nxt   = r_cnt;
      w_gc_nxt    = r_gc;
      w_load      = 1'b0;
      ShiftEnable = 1'b0;
      ShiftOut    = 1'b0;
      WordDone    = 1'b0;
      unique case (r_state)
         ST_IDLE: w_load = r_hold_v;
         ST_SHIFT: begin
            ShiftEnable = ~Pause;
            ShiftOut    = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
            if (!Pause) begin
               w_sh_nxt  = w_sh_shifted;
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_last) begin
                  WordDone = 1'b1;
                  if (GAP > 0) begin
                     w_gc_nxt    = 4'(GAP - 1);
                     w_state_nxt = ST_GAP;
                  end else if (r_hold_v) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
         end
         ST_GAP: begin
            if (!Pause) begin
               if (r_gc == 4'd0) begin
                  if (r_hold_v) w_load = 1'b1;
                  else          w_state_nxt = ST_IDLE;
               end else begin
                  w_gc_nxt = r_gc - 4'd1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // A reload always starts a fresh word, overriding the shift/count above.
      if (w_load) begin
         w_sh_nxt    = r_hold;
         w_cnt_nxt   = '0;
         w_state_nxt = ST_SHIFT;
      end
      // Load needs hold_v=1 and accept needs hold_v=0, so they never collide.
      w_hold_v_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_v);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= ST_IDLE;
         r_hold_v <= 1'b0;
         r_cnt    <= '0;
         r_gc     <= '0;
         r_sh     <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_hold_v <= w_hold_v_nxt;
         r_cnt    <= w_cnt_nxt;
         r_gc     <= w_gc_nxt;
         r_sh     <= w_sh_nxt;
      end
   end

   // NOTE: hold is pure data qualified by hold_v, so it is deliberately left out of reset.
   always_ff @(posedge Clock) begin
      if (w_accept) r_hold <= DataIn;
   end

endmodule

// File: tb/tb_sreg8_serializer.sv
// Scoreboard bench: three serializer configurations share stimulus; each has a
// feeder pushing expected bits on accept and a monitor checking the serial stream.
module tb_sreg8_serializer;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic [2:0] dv, rdy, so, se, wd, busy;
   logic       pause;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic b;
      logic last;
   } bit_t;

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp, input int inst);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, inst, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // inst0: MSB first, no gap; inst1: LSB first, no gap; inst2: MSB first, gap of 3
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam bit MSBF = (g != 1);
      localparam int GAPV = (g == 2) ? 3 : 0;

      sreg8_serializer #(.WIDTH(8), .MSB_FIRST(MSBF), .GAP(GAPV)) u_dut (
         .Clock      (clk),
         .Reset      (rst),
         .DataIn     (din),
         .DataValid  (dv[g]),
         .DataReady  (rdy[g]),
         .Pause      (pause),
         .ShiftOut   (so[g]),
         .ShiftEnable(se[g]),
         .WordDone   (wd[g]),
         .Busy       (busy[g])
      );

      bit_t q[$];
      int   gap_left  = 0;
      bit   arm       = 1'b0;
      bit   lat_armed = 1'b0;
      int   lat_cnt   = 0;

      // Feeder: an accepted word becomes WIDTH expected bits in emission order.
      initial forever begin
         logic       take;
         logic [7:0] w;
         bit_t       e;
         int         idx;
         @(negedge clk);
         take = dv[g] & rdy[g];
         w    = din;
         @(posedge clk);
         if (take) begin
            if (q.size() == 0 && gap_left == 0) begin
               lat_armed = 1'b1;
               lat_cnt   = 0;
            end
            for (int i = 0; i < 8; i++) begin
               idx    = MSBF ? 7 - i : i;
               e.b    = w[idx];
               e.last = (i == 7);
               q.push_back(e);
            end
         end
      end

      // Monitor
      initial forever begin
         bit_t e;
         bit   ok;
         @(negedge clk);
         if (rst) begin
            check("ready_in_reset", rdy[g], 0, g);
            q.delete();
            gap_left  = 0;
            arm       = 1'b0;
            lat_armed = 1'b0;
         end else begin
            if (lat_armed) begin
               lat_cnt++;
               if (lat_cnt == 1) begin
                  check("latency_early", se[g], 0, g);
               end else begin
                  if (!pause) check("latency_first", se[g], 1, g);
                  lat_armed = 1'b0;
               end
            end
            check("busy", busy[g], (q.size() > 0 || gap_left > 0) ? 1 : 0, g);
            if (q.size() == 0)      check("ready_empty", rdy[g], 1, g);
            else if (q.size() > 8)  check("ready_full", rdy[g], 0, g);
            if (se[g]) begin
               if (q.size() == 0) begin
                  check("unexpected_bit", se[g], 0, g);
               end else begin
                  e = q.pop_front();
                  check("shift_out", so[g], e.b, g);
                  check("word_done", wd[g], e.last, g);
                  check("gap_short", gap_left, 0, g);
                  arm = 1'b0;
                  if (e.last) begin
                     gap_left = GAPV;
                     arm      = (q.size() > 0);
                  end
               end
            end else begin
               check("word_done_idle", wd[g], 0, g);
               if (!pause) begin
                  check("out_idle", so[g], 0, g);
                  if (arm && gap_left == 0) check("bubble", se[g], 1, g);
                  if (gap_left > 0) gap_left--;
               end else begin
                  ok = (so[g] == 1'b0) || (q.size() > 0 && so[g] == q[0].b);
                  check("pause_hold", ok, 1, g);
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] w);
      logic [2:0] acc;
      int         n;
      n   = 0;
      din = w;
      dv  = 3'b111;
      while (dv != 3'b000) begin
         @(negedge clk);
         acc = dv & rdy;
         @(posedge clk);
         #1;
         dv = dv & ~acc;
         n++;
         if (n > 400) begin
            fail_now("send_timeout");
            dv = 3'b000;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy != 3'b000 && n < 1000);
      if (n >= 1000) fail_now("idle_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic count_enables(input int k);
      int n, c;
      n = 0;
      c = 0;
      while (n < k && c < 100) begin
         @(negedge clk);
         if (se[0]) n++;
         c++;
      end
      if (n < k) fail_now("enable_count");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit done;
      rst   = 1'b1;
      dv    = 3'b000;
      din   = 8'h00;
      pause = 1'b0;
      done  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      send(8'hA5);
      wait_idle();

      send(8'hFF);
      send(8'h00);
      wait_idle();

      send(8'hF0);
      count_enables(4);
      @(posedge clk);
      #1 pause = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      pause = 1'b0;
      wait_idle();

      send(8'h0F);
      send(8'h3C);
      wait_idle();

      send(8'h01);
      wait_idle();

      send(8'hAA);
      fork
         send(8'h55);
         begin
            count_enables(3);
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      wait_idle();

      fork
         begin
            for (int k = 0; k < 250; k++) begin
               int idle_cycles;
               idle_cycles = $urandom_range(0, 3);
               repeat (idle_cycles) begin
                  @(posedge clk);
                  #1;
               end
               send(8'($urandom));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               pause = ($urandom_range(0, 4) == 0);
               rst   = ($urandom_range(0, 150) == 0);
            end
            pause = 1'b0;
            rst   = 1'b0;
         end
      join
      wait_idle();
      repeat (4) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
